// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and baud divisor helper.
// Used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam int DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Modulo-CLKS_PER_BIT bit-period counter with synchronous clear.
// bit_end marks the last clock of each bit period.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 10,
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             bit_end
);

    assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte input and a registered tx line.
// tx changes on the same edge as the state, so each level lasts exactly one bit period.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = $clog2(DATA_BITS);

    generate
        if (CLKS_PER_BIT < 2) begin : g_cpb_check
            $error("uart_tx: CLK_HZ/BAUD must be at least 2");
        end
    endgenerate

    uart_state_t          state;
    logic [DATA_BITS-1:0] shift;
    logic [IDX_W-1:0]     bit_idx;
    logic [CNT_W-1:0]     baud_cnt;
    logic                 bit_end;
    logic                 stop_penult;

    assign tx_ready = (state == IDLE);
    assign tx_busy  = !tx_ready;

    // Holding the counter clear in IDLE makes every frame start from count 0;
    // later state entries coincide with the bit_end wrap.
    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == IDLE),
        .cnt    (baud_cnt),
        .bit_end(bit_end)
    );

    // tx_done is registered, so it is raised one cycle ahead of the final stop cycle.
    assign stop_penult = (state == STOP) && (baud_cnt == CNT_W'(CLKS_PER_BIT - 2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_valid) begin
                        shift   <= tx_data;
                        bit_idx <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx    <= shift[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (stop_penult) begin
                        tx_done <= 1'b1;
                    end
                    if (bit_end) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx: per-cycle frame waveform checks plus a mid-bit sampling monitor.
// Directed cases cover handshake hold-off, data changes while busy, reset abort and boundary bytes.
module tb_uart_tx;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int FRAME  = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    logic [3:0] obs;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    assign obs = {tx, tx_busy, tx_ready, tx_done};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected {tx, busy, ready, done} for cycle i of a frame, i=0 being the first start-bit cycle.
    function automatic logic [3:0] frame_vec(input logic [7:0] b, input int i);
        int   k;
        logic lvl;
        k = i / CPB;
        if (k == 0)      lvl = 1'b0;
        else if (k == 9) lvl = 1'b1;
        else             lvl = b[k-1];
        return {lvl, 1'b1, 1'b0, (i == FRAME - 1)};
    endfunction

    // Wait (bounded) for ready, then present b for exactly one accept cycle.
    task automatic send(input logic [7:0] b);
        int w = 0;
        while (!tx_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Called at the negedge of the first start-bit cycle; returns at the first idle cycle.
    task automatic check_frame(input logic [7:0] b, input string tag);
        exp_q.push_back(b);
        for (int i = 0; i < FRAME; i++) begin
            chk(tag, obs, frame_vec(b, i));
            @(negedge clk);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk(tag, obs, 4'b1010);
    endtask

    // Line monitor: finds the start edge, samples each bit at mid-period, checks the stop bit.
    // A frame cut short by reset shows up as ready returning high mid-frame and is dropped.
    initial begin
        int         t;
        int         k;
        logic       act;
        logic       ok;
        logic [7:0] d;
        act = 1'b0;
        t   = 0;
        ok  = 1'b1;
        d   = 8'h00;
        forever begin
            @(negedge clk);
            if (act && tx_ready) begin
                act = 1'b0;
            end else if (!act) begin
                if (tx === 1'b0) begin
                    act = 1'b1;
                    t   = 0;
                    ok  = 1'b1;
                end
            end else begin
                t++;
                if (t % CPB == CPB / 2) begin
                    k = t / CPB;
                    if (k == 0) begin
                        if (tx !== 1'b0) ok = 1'b0;
                    end else if (k <= 8) begin
                        d[k-1] = tx;
                    end else begin
                        act = 1'b0;
                        if (exp_q.size() == 0) chk("mon_extra", 1, 0);
                        else chk("mon_byte", {ok, tx, d}, {2'b11, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        int         dc;

        // Reset state
        repeat (3) @(negedge clk);
        idle_chk("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        idle_chk("rst_release");

        // Single byte
        send(8'hA5);
        check_frame(8'hA5, "single_a5");
        idle_chk("single_end");

        // Held-off handshake: 3C waits through the whole 00 frame
        chk("held_ready", tx_ready, 1);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h3C;
        check_frame(8'h00, "held_a");
        idle_chk("held_gap");
        @(negedge clk);
        tx_valid = 1'b0;
        check_frame(8'h3C, "held_b");
        idle_chk("held_end");

        // Data change while busy
        send(8'hFF);
        tx_data = 8'h00;
        check_frame(8'hFF, "busy_change");
        idle_chk("busy_change_end");

        // Reset during data bit 3 of 55
        send(8'h55);
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_chk("rst_abort");
        dc = 0;
        repeat (3 * CPB) begin
            if (tx_done) dc++;
            @(negedge clk);
        end
        chk("rst_no_done", dc, 0);
        send(8'h81);
        check_frame(8'h81, "after_rst");
        idle_chk("after_rst_end");

        // Boundary bytes back-to-back: 00 then FF with one idle cycle between
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'hFF;
        check_frame(8'h00, "bound_00");
        idle_chk("bound_gap");
        @(negedge clk);
        tx_valid = 1'b0;
        check_frame(8'hFF, "bound_ff");
        idle_chk("bound_end");

        // Random bytes with random producer delay
        for (int n = 0; n < 256; n++) begin
            b = 8'($urandom);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send(b);
            check_frame(b, "rand");
        end
        idle_chk("rand_end");

        repeat (2 * CPB) @(negedge clk);
        chk("mon_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
